// File: rtl/coo_aggregation_ctrl_if.sv
// Control bundle between the COO aggregation sequencer and its memories/datapath.
// master = sequencer side, slave = GCN controller / memories / accumulator side.
interface coo_aggregation_ctrl_if #(
  parameter int COO_BW  = 3,
  parameter int NODE_BW = 3
) ();
  logic               start;
  logic [NODE_BW-1:0] coo_row_in;
  logic [NODE_BW-1:0] coo_col_in;
  logic               coo_rd_en;
  logic [COO_BW-1:0]  coo_rd_addr;
  logic               fm_rd_en;
  logic [NODE_BW-1:0] fm_rd_addr;
  logic               acc_en;
  logic               acc_clr;
  logic               wr_en;
  logic [NODE_BW-1:0] wr_addr;
  logic               busy;
  logic               done;

  modport master (
    input  start, coo_row_in, coo_col_in,
    output coo_rd_en, coo_rd_addr, fm_rd_en, fm_rd_addr,
           acc_en, acc_clr, wr_en, wr_addr, busy, done
  );

  modport slave (
    output start, coo_row_in, coo_col_in,
    input  coo_rd_en, coo_rd_addr, fm_rd_en, fm_rd_addr,
           acc_en, acc_clr, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/coo_aggregation_ctrl.sv
// Walks the COO edge list one edge per 4 cycles (+1 per destination change), flushing the
// accumulator on row change and after the last edge; no backpressure, start honoured only in IDLE.
module coo_aggregation_ctrl #(
  parameter int COO_EDGES = 6,
  parameter int COO_BW    = $clog2(COO_EDGES),
  parameter int NODES     = 6,
  parameter int NODE_BW   = $clog2(NODES)
) (
  input  logic                   clk,
  input  logic                   reset,
  coo_aggregation_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COO_RD,
    S_COO_WAIT,
    S_FLUSH,
    S_FM_RD,
    S_ACC,
    S_LAST_WR,
    S_DONE
  } state_e;

  localparam logic [COO_BW-1:0] LAST_EDGE = COO_BW'(COO_EDGES - 1);

  state_e             state_q, state_d;
  logic [COO_BW-1:0]  edge_cnt_q, edge_cnt_d;
  logic [NODE_BW-1:0] cur_dst_q, cur_dst_d;
  logic [NODE_BW-1:0] src_q, src_d;
  logic [NODE_BW-1:0] dst_q, dst_d;

  logic               coo_rd_en_q, coo_rd_en_d;
  logic [COO_BW-1:0]  coo_rd_addr_q, coo_rd_addr_d;
  logic               fm_rd_en_q, fm_rd_en_d;
  logic [NODE_BW-1:0] fm_rd_addr_q, fm_rd_addr_d;
  logic               acc_en_q, acc_en_d;
  logic               acc_clr_q, acc_clr_d;
  logic               wr_en_q, wr_en_d;
  logic [NODE_BW-1:0] wr_addr_q, wr_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      edge_cnt_q    <= '0;
      cur_dst_q     <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      coo_rd_en_q   <= 1'b0;
      coo_rd_addr_q <= '0;
      fm_rd_en_q    <= 1'b0;
      fm_rd_addr_q  <= '0;
      acc_en_q      <= 1'b0;
      acc_clr_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      cur_dst_q     <= cur_dst_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      coo_rd_en_q   <= coo_rd_en_d;
      coo_rd_addr_q <= coo_rd_addr_d;
      fm_rd_en_q    <= fm_rd_en_d;
      fm_rd_addr_q  <= fm_rd_addr_d;
      acc_en_q      <= acc_en_d;
      acc_clr_q     <= acc_clr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    cur_dst_d  = cur_dst_q;
    src_d      = src_q;
    dst_d      = dst_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          edge_cnt_d = '0;
          state_d    = S_COO_RD;
        end
      end
      S_COO_RD: state_d = S_COO_WAIT;
      S_COO_WAIT: begin
        src_d = bus.coo_col_in;
        dst_d = bus.coo_row_in;
        // The first edge seeds the current row; later edges flush the old row on change.
        if (edge_cnt_q == '0) begin
          cur_dst_d = bus.coo_row_in;
          state_d   = S_FM_RD;
        end else if (bus.coo_row_in != cur_dst_q) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_FM_RD;
        end
      end
      S_FLUSH: begin
        cur_dst_d = dst_q;
        state_d   = S_FM_RD;
      end
      S_FM_RD: state_d = S_ACC;
      S_ACC: begin
        if (edge_cnt_q == LAST_EDGE) begin
          state_d = S_LAST_WR;
        end else begin
          edge_cnt_d = edge_cnt_q + COO_BW'(1);
          state_d    = S_COO_RD;
        end
      end
      S_LAST_WR: state_d = S_DONE;
      S_DONE: begin
        edge_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with state_q.
  always_comb begin
    coo_rd_en_d   = (state_d == S_COO_RD);
    coo_rd_addr_d = coo_rd_en_d ? edge_cnt_d : '0;
    fm_rd_en_d    = (state_d == S_FM_RD);
    fm_rd_addr_d  = fm_rd_en_d ? src_d : '0;
    acc_en_d      = (state_d == S_ACC);
    wr_en_d       = (state_d == S_FLUSH) || (state_d == S_LAST_WR);
    acc_clr_d     = wr_en_d;
    wr_addr_d     = wr_en_d ? cur_dst_d : '0;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  assign bus.coo_rd_en   = coo_rd_en_q;
  assign bus.coo_rd_addr = coo_rd_addr_q;
  assign bus.fm_rd_en    = fm_rd_en_q;
  assign bus.fm_rd_addr  = fm_rd_addr_q;
  assign bus.acc_en      = acc_en_q;
  assign bus.acc_clr     = acc_clr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_coo_aggregation_ctrl.sv
// Scoreboard bench for coo_aggregation_ctrl: a COO memory model answers reads, the
// expected strobe/address stream is derived from the edge list and checked by a monitor.
module tb_coo_aggregation_ctrl;
  localparam int N = 6;

  typedef struct {
    int addr;
    int accs;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  coo_aggregation_ctrl_if #(.COO_BW(3), .NODE_BW(3)) bus ();

  coo_aggregation_ctrl #(
    .COO_EDGES(N),
    .COO_BW   (3),
    .NODES    (6),
    .NODE_BW  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int acc_seen = 0;
  bit pass_active = 1'b0;

  int rows_m[N];
  int cols_m[N];
  logic [2:0] mem_row[8];
  logic [2:0] mem_col[8];

  int      q_coo[$];
  int      q_fm[$];
  int      q_acc[$];
  int      q_done[$];
  wr_exp_t q_wr[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag_err(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] outs_now();
    return {bus.coo_rd_en, bus.coo_rd_addr, bus.fm_rd_en, bus.fm_rd_addr, bus.acc_en,
            bus.acc_clr, bus.wr_en, bus.wr_addr, bus.busy, bus.done};
  endfunction

  // COO memory: data appears after the read strobe and holds until the next read.
  initial begin
    bus.coo_row_in = '0;
    bus.coo_col_in = '0;
    forever begin
      @(negedge clk);
      if (bus.coo_rd_en) begin
        bus.coo_row_in = mem_row[bus.coo_rd_addr];
        bus.coo_col_in = mem_col[bus.coo_rd_addr];
      end
    end
  end

  // Monitor: pops the expected stream whenever the DUT presents a strobe.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("strobe_exclusive", int'($countones({bus.acc_en, bus.wr_en, bus.fm_rd_en, bus.coo_rd_en}) <= 1), 1);
      check("acc_clr_with_wr", int'(bus.acc_clr), int'(bus.wr_en));
      check("busy", int'(bus.busy), int'(pass_active));
      if (bus.coo_rd_en) begin
        if (q_coo.size() == 0) flag_err("unexpected_coo_rd");
        else check("coo_rd_addr", int'(bus.coo_rd_addr), q_coo.pop_front());
      end
      if (bus.fm_rd_en) begin
        if (q_fm.size() == 0) flag_err("unexpected_fm_rd");
        else check("fm_rd_addr", int'(bus.fm_rd_addr), q_fm.pop_front());
      end
      if (bus.acc_en) begin
        if (q_acc.size() == 0) flag_err("unexpected_acc_en");
        else void'(q_acc.pop_front());
        acc_seen++;
      end
      if (bus.wr_en) begin
        if (q_wr.size() == 0) flag_err("unexpected_wr_en");
        else begin
          wr_exp_t w;
          w = q_wr.pop_front();
          check("wr_addr", int'(bus.wr_addr), w.addr);
          check("wr_after_accs", acc_seen, w.accs);
        end
      end
      if (bus.done) begin
        if (q_done.size() == 0) flag_err("unexpected_done");
        else check("done_latency", cyc - start_cyc, q_done.pop_front());
        pass_active = 1'b0;
      end
    end
  end

  task automatic clear_queues();
    q_coo.delete();
    q_fm.delete();
    q_acc.delete();
    q_wr.delete();
    q_done.delete();
  endtask

  // Reference: one read per edge, one write per run of equal rows, 4 cycles/edge + flushes + 2.
  task automatic build_expect();
    int d;
    clear_queues();
    d = 1;
    for (int i = 0; i < N; i++) begin
      mem_row[i] = 3'(rows_m[i]);
      mem_col[i] = 3'(cols_m[i]);
      q_coo.push_back(i);
      q_fm.push_back(cols_m[i]);
      q_acc.push_back(i);
    end
    for (int i = 1; i < N; i++) begin
      if (rows_m[i] != rows_m[i-1]) begin
        q_wr.push_back('{rows_m[i-1], i});
        d++;
      end
    end
    q_wr.push_back('{rows_m[N-1], N});
    q_done.push_back(4 * N + (d - 1) + 2);
  endtask

  task automatic issue_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic begin_pass();
    build_expect();
    acc_seen = 0;
    issue_start();
    start_cyc = cyc;
    pass_active = 1'b1;
    check("first_coo_rd_en", int'(bus.coo_rd_en), 1);
    check("first_coo_rd_addr", int'(bus.coo_rd_addr), 0);
  endtask

  task automatic run_pass(input bit mid_start);
    begin_pass();
    if (mid_start) begin
      repeat (12) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    for (int i = 0; i < 200 && pass_active; i++) @(negedge clk);
    if (pass_active) begin
      flag_err("done_timeout");
      pass_active = 1'b0;
    end
    check("coo_rd_left", q_coo.size(), 0);
    check("fm_rd_left", q_fm.size(), 0);
    check("acc_left", q_acc.size(), 0);
    check("wr_left", q_wr.size(), 0);
    check("done_left", q_done.size(), 0);
    clear_queues();
    repeat (3) @(negedge clk);
  endtask

  task automatic load_default();
    int r[N] = '{0, 0, 1, 2, 2, 2};
    int c[N] = '{1, 2, 0, 0, 1, 3};
    rows_m = r;
    cols_m = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_row[i] = '0;
      mem_col[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("outs_in_reset", int'(outs_now()), 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1 check("idle_outs", int'(outs_now()), 0);
    end

    load_default();
    run_pass(1'b1);
    run_pass(1'b0);

    for (int i = 0; i < N; i++) begin
      rows_m[i] = 4;
      cols_m[i] = int'($urandom_range(0, 5));
    end
    run_pass(1'b0);

    for (int i = 0; i < N; i++) begin
      rows_m[i] = i;
      cols_m[i] = int'($urandom_range(0, 5));
    end
    run_pass(1'b0);

    for (int p = 0; p < 8; p++) begin
      r = int'($urandom_range(0, 5));
      for (int i = 0; i < N; i++) begin
        if (i > 0) begin
          r = r + int'($urandom_range(0, 2));
          if (r > 5) r = 5;
        end
        rows_m[i] = r;
        cols_m[i] = int'($urandom_range(0, 5));
      end
      run_pass(1'b0);
    end

    // Abort in the ACC cycle of edge 2, then rerun the same list from scratch.
    load_default();
    begin_pass();
    for (int i = 0; i < 100 && acc_seen < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("abort_acc_count", acc_seen, 3);
    check("abort_in_acc", int'(bus.acc_en), 1);
    reset = 1'b0;
    #1 check("outs_async_reset", int'(outs_now()), 0);
    pass_active = 1'b0;
    clear_queues();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    run_pass(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
